dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: the core pipeline LD/ST port (req 0)
//  and the network DMA port (req 1). Grants one whole transaction at a time using the valid/yumi

---
 rtl/dmem_arbiter_pkg.sv | 28 ++
 rtl/dmem_arbiter_pick2.sv | 21 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared memory-port types plus arbiter state and requester ids.
// Requester id doubles as the bit index into one-hot grant vectors.
package dmem_arbiter_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_e;

  localparam int ARB_CORE_ID = 0;
  localparam int ARB_NET_ID  = 1;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Two-way one-hot picker: a lone requester always wins; on contention the core
// wins when fixed priority is on or prio is 0, otherwise the network wins.
module arb_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  input  logic       fixed,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[ARB_CORE_ID] && (!valid[ARB_NET_ID] || fixed || !prio)) begin
      grant[ARB_CORE_ID] = 1'b1;
    end else if (valid[ARB_NET_ID]) begin
      grant[ARB_NET_ID] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between core and network, one whole transaction at a time.
// Grant registered one cycle after a request appears; the owner's handshake passes straight through.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter bit CORE_PRIORITY_P = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     core_req_i,
  input  logic [31:0] core_addr_i,
  output mem_out_s    core_resp_o,
  input  mem_in_s     net_req_i,
  input  logic [31:0] net_addr_i,
  output mem_out_s    net_resp_o,
  output mem_in_s     mem_req_o,
  output logic [31:0] mem_addr_o,
  input  mem_out_s    mem_resp_i,
  output logic [1:0]  grant_o,
  output logic        err_o
);

  arb_state_e  state_r;
  logic [1:0]  grant_r;
  logic        prio_r;
  logic        err_r;
  logic [1:0]  pick;
  mem_in_s     own_req;
  logic [31:0] own_addr;
  mem_out_s    own_resp;
  logic        own_done;

  arb_pick2 u_pick (
    .valid ({net_req_i.valid, core_req_i.valid}),
    .prio  (prio_r),
    .fixed (CORE_PRIORITY_P),
    .grant (pick)
  );

  assign own_req  = grant_r[ARB_NET_ID] ? net_req_i  : core_req_i;
  assign own_addr = grant_r[ARB_NET_ID] ? net_addr_i : core_addr_i;
  assign own_done = mem_resp_i.valid && own_req.yumi;

  always_comb begin
    mem_req_o  = '0;
    mem_addr_o = '0;
    own_resp   = '0;
    case (state_r)
      // Stray responses are drained so the memory does not stall holding them.
      ARB_IDLE: mem_req_o.yumi = mem_resp_i.valid;
      ARB_ISSUE: begin
        mem_req_o  = own_req;
        mem_addr_o = own_addr;
        own_resp   = mem_resp_i;
      end
      ARB_RESP: begin
        mem_req_o.yumi     = own_req.yumi;
        own_resp.read_data = mem_resp_i.read_data;
        own_resp.valid     = mem_resp_i.valid;
      end
      default: ;
    endcase
  end

  assign core_resp_o = grant_r[ARB_CORE_ID] ? own_resp : '0;
  assign net_resp_o  = grant_r[ARB_NET_ID]  ? own_resp : '0;
  assign grant_o     = grant_r;
  assign err_o       = err_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ARB_IDLE;
      grant_r <= 2'b00;
      prio_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (mem_resp_i.valid) err_r <= 1'b1;
          if (|pick) begin
            grant_r <= pick;
            state_r <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (own_done) begin
            state_r <= ARB_IDLE;
            grant_r <= 2'b00;
            prio_r  <= ~grant_r[ARB_NET_ID];
          end else if (mem_resp_i.yumi) begin
            state_r <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (own_done) begin
            state_r <= ARB_IDLE;
            grant_r <= 2'b00;
            prio_r  <= ~grant_r[ARB_NET_ID];
          end
        end
        default: state_r <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter: round-robin and fixed-priority instances
// share stimulus; the selected instance is compared against hand-computed expectations.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  mem_in_s     core_req, net_req;
  logic [31:0] core_addr, net_addr;
  mem_out_s    mem_resp;
  logic        sel = 1'b0;

  mem_out_s    rr_core_resp, rr_net_resp, fp_core_resp, fp_net_resp;
  mem_in_s     rr_mem_req, fp_mem_req;
  logic [31:0] rr_mem_addr, fp_mem_addr;
  logic [1:0]  rr_grant, fp_grant;
  logic        rr_err, fp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.CORE_PRIORITY_P(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_resp_o(rr_core_resp),
    .net_req_i(net_req), .net_addr_i(net_addr), .net_resp_o(rr_net_resp),
    .mem_req_o(rr_mem_req), .mem_addr_o(rr_mem_addr), .mem_resp_i(mem_resp),
    .grant_o(rr_grant), .err_o(rr_err)
  );

  dmem_arbiter #(.CORE_PRIORITY_P(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_resp_o(fp_core_resp),
    .net_req_i(net_req), .net_addr_i(net_addr), .net_resp_o(fp_net_resp),
    .mem_req_o(fp_mem_req), .mem_addr_o(fp_mem_addr), .mem_resp_i(mem_resp),
    .grant_o(fp_grant), .err_o(fp_err)
  );

  typedef struct {
    logic        rst;
    logic        cv;  logic [31:0] ca;  logic cy;
    logic        nv;  logic [31:0] na;  logic ny;
    logic        mv;  logic [31:0] md;  logic my;
    logic [1:0]  g;
    logic        qv;  logic qy;  logic [31:0] qa;
    logic        crv; logic cry; logic [31:0] crd;
    logic        nrv; logic nry; logic [31:0] nrd;
    logic        err;
  } vec_t;

  vec_t rr_tab[$];
  vec_t fp_tab[$];

  function automatic vec_t mk(
    input logic rst, cv, input logic [31:0] ca, input logic cy,
    input logic nv, input logic [31:0] na, input logic ny,
    input logic mv, input logic [31:0] md, input logic my,
    input logic [1:0] g, input logic qv, qy, input logic [31:0] qa,
    input logic crv, cry, input logic [31:0] crd,
    input logic nrv, nry, input logic [31:0] nrd, input logic err);
    vec_t v;
    v.rst = rst; v.cv = cv; v.ca = ca; v.cy = cy; v.nv = nv; v.na = na; v.ny = ny;
    v.mv = mv; v.md = md; v.my = my; v.g = g; v.qv = qv; v.qy = qy; v.qa = qa;
    v.crv = crv; v.cry = cry; v.crd = crd; v.nrv = nrv; v.nry = nry; v.nrd = nrd; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, cv, input logic [31:0] ca, input logic cy,
                       input logic nv, input logic [31:0] na, input logic ny,
                       input logic mv, input logic [31:0] md, input logic my);
    reset     = rst;
    core_req  = '{write_data: 32'h1111_0000, valid: cv, wen: 1'b0, byte_not_word: 1'b0, yumi: cy};
    core_addr = ca;
    net_req   = '{write_data: 32'h2222_0000, valid: nv, wen: 1'b1, byte_not_word: 1'b0, yumi: ny};
    net_addr  = na;
    mem_resp  = '{read_data: md, valid: mv, yumi: my};
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int row);
    mem_out_s cr, nr;
    mem_in_s  q;
    drive(v.rst, v.cv, v.ca, v.cy, v.nv, v.na, v.ny, v.mv, v.md, v.my);
    @(negedge clk);
    cr = sel ? fp_core_resp : rr_core_resp;
    nr = sel ? fp_net_resp  : rr_net_resp;
    q  = sel ? fp_mem_req   : rr_mem_req;
    check("grant",     row, 64'(sel ? fp_grant : rr_grant), 64'(v.g));
    check("mem_valid", row, 64'(q.valid), 64'(v.qv));
    check("mem_yumi",  row, 64'(q.yumi), 64'(v.qy));
    check("mem_addr",  row, 64'(sel ? fp_mem_addr : rr_mem_addr), 64'(v.qa));
    check("core_resp", row, 64'(cr), 64'({v.crd, v.crv, v.cry}));
    check("net_resp",  row, 64'(nr), 64'({v.nrd, v.nrv, v.nry}));
    check("err",       row, 64'(sel ? fp_err : rr_err), 64'(v.err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // rst, cv,ca,cy, nv,na,ny, mv,md,my, g,qv,qy,qa, crv,cry,crd, nrv,nry,nrd, err
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    // core-only load
    rr_tab.push_back(mk(1, 1,'h40,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 1,'h40,0, 0,0,0, 0,0,0, 2'b01,1,0,'h40, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 1,'h40,0, 0,0,0, 0,0,1, 2'b01,1,0,'h40, 0,1,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b01,0,0,0, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,1, 0,0,0, 1,'hDEADBEEF,0, 2'b01,0,1,0, 1,0,'hDEADBEEF, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    // net transaction completing in ARB_ISSUE
    rr_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b10,1,0,'h80, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h80,1, 1,'hCAFEF00D,1, 2'b10,1,1,'h80, 0,0,0, 1,1,'hCAFEF00D, 0));
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    // stray response while idle
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 1,0,0, 2'b00,0,1,0, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 1));
    // joint requests, round-robin: core, then net, then core again
    rr_tab.push_back(mk(1, 1,'h44,0, 1,'h84,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h44,0, 1,'h84,0, 0,0,0, 2'b01,1,0,'h44, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h44,0, 1,'h84,0, 0,0,1, 2'b01,1,0,'h44, 0,1,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h84,0, 0,0,0, 2'b01,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,1, 1,'h84,0, 1,'h11,0, 2'b01,0,1,0, 1,0,'h11, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h84,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 1,'h84,0, 0,0,0, 2'b10,1,0,'h84, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 1,'h84,0, 0,0,1, 2'b10,1,0,'h84, 0,0,0, 0,1,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 0,0,0, 0,0,0, 2'b10,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 0,0,1, 1,'h22,0, 2'b10,0,1,0, 0,0,0, 1,0,'h22, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 1,'h88,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 1,'h88,0, 0,0,0, 2'b01,1,0,'h48, 0,0,0, 0,0,0, 1));
    // early valid drop keeps the grant
    rr_tab.push_back(mk(1, 0,'h48,0, 1,'h88,0, 0,0,0, 2'b01,0,0,'h48, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h48,0, 1,'h88,0, 0,0,1, 2'b01,1,0,'h48, 0,1,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h88,0, 0,0,0, 2'b01,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,1, 1,'h88,0, 1,'h33,0, 2'b01,0,1,0, 1,0,'h33, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h88,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h88,0, 0,0,0, 2'b10,1,0,'h88, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 1,'h88,0, 0,0,1, 2'b10,1,0,'h88, 0,0,0, 0,1,0, 1));
    rr_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b10,0,0,0, 0,0,0, 0,0,0, 1));
    // reset while in ARB_RESP with prio pointing at net; afterwards core wins a joint request
    rr_tab.push_back(mk(0, 0,0,0, 0,0,0, 0,0,0, 2'b10,0,0,0, 0,0,0, 0,0,0, 1));
    rr_tab.push_back(mk(1, 1,'h4C,0, 1,'h8C,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    rr_tab.push_back(mk(1, 1,'h4C,0, 1,'h8C,0, 0,0,0, 2'b01,1,0,'h4C, 0,0,0, 0,0,0, 0));

    // fixed priority: core wins every contention, net only when core idle
    fp_tab.push_back(mk(1, 1,'h40,0, 1,'h80,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 1,'h40,0, 1,'h80,0, 0,0,0, 2'b01,1,0,'h40, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 1,'h40,0, 1,'h80,0, 0,0,1, 2'b01,1,0,'h40, 0,1,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b01,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,1, 1,'h80,0, 1,'h1,0, 2'b01,0,1,0, 1,0,'h1, 0,0,0, 0));
    fp_tab.push_back(mk(1, 1,'h44,0, 1,'h80,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 1,'h44,0, 1,'h80,0, 0,0,0, 2'b01,1,0,'h44, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 1,'h44,0, 1,'h80,0, 0,0,1, 2'b01,1,0,'h44, 0,1,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b01,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,1, 1,'h80,0, 1,'h2,0, 2'b01,0,1,0, 1,0,'h2, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,0, 2'b10,1,0,'h80, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 1,'h80,0, 0,0,1, 2'b10,1,0,'h80, 0,0,0, 0,1,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b10,0,0,0, 0,0,0, 0,0,0, 0));
    fp_tab.push_back(mk(1, 0,0,0, 0,0,1, 1,'h3,0, 2'b10,0,1,0, 0,0,0, 1,0,'h3, 0));
    fp_tab.push_back(mk(1, 0,0,0, 0,0,0, 0,0,0, 2'b00,0,0,0, 0,0,0, 0,0,0, 0));

    sel = 1'b0;
    do_reset();
    foreach (rr_tab[i]) apply(rr_tab[i], i);

    sel = 1'b1;
    do_reset();
    foreach (fp_tab[i]) apply(fp_tab[i], 100 + i);

    // net store after reset: bounded wait for the issue cycle
    sel = 1'b0;
    do_reset();
    drive(1, 0, 0, 0, 1, 32'h90, 0, 0, 0, 0);
    n = 0;
    while (!rr_mem_req.valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("issue_latency", 200, 64'(n), 64'd1);
    check("issue_addr",    200, 64'(rr_mem_addr), 64'h90);
    check("issue_wen",     200, 64'(rr_mem_req.wen), 64'd1);
    check("issue_wdata",   200, 64'(rr_mem_req.write_data), 64'h2222_0000);
    check("issue_grant",   200, 64'(rr_grant), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
